// File: rtl/zeus_bus_pkg.sv
// Shared types and constants for the Zeus CPU bus cycle controller.
package zeus_bus_pkg;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_VRAM,
    REG_VIDEO,
    REG_IRQ,
    REG_SPI,
    REG_MMU,
    REG_EXT
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACTIVE
  } state_t;

  // Inclusive upper offsets of the on-chip I/O register blocks inside the I/O page
  localparam logic [7:0] OFF_VIDEO_HI = 8'h1F;
  localparam logic [7:0] OFF_IRQ_HI   = 8'h2F;
  localparam logic [7:0] OFF_SPI_HI   = 8'h3F;
  localparam logic [7:0] OFF_MMU_HI   = 8'h4F;

  localparam int SEL_VIDEO = 0;
  localparam int SEL_IRQ   = 1;
  localparam int SEL_SPI   = 2;
  localparam int SEL_MMU   = 3;
  localparam int SEL_RAM   = 4;
  localparam int SEL_VRAM  = 5;

  localparam logic [5:0] SEL_NONE = 6'h3F;

  // Active-low select vector for a region; EXT leaves every select high
  function automatic logic [5:0] sel_for(input region_t r);
    logic [5:0] sel;
    sel = SEL_NONE;
    case (r)
      REG_VIDEO: sel[SEL_VIDEO] = 1'b0;
      REG_IRQ:   sel[SEL_IRQ]   = 1'b0;
      REG_SPI:   sel[SEL_SPI]   = 1'b0;
      REG_MMU:   sel[SEL_MMU]   = 1'b0;
      REG_RAM:   sel[SEL_RAM]   = 1'b0;
      REG_VRAM:  sel[SEL_VRAM]  = 1'b0;
      default:   sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/bus_region_decode.sv
// Combinational decode of a 24-bit CPU bank:address into the region it targets.
module bus_region_decode
  import zeus_bus_pkg::*;
#(
  parameter logic [15:0] IO_PAGE      = 16'hFE00,
  parameter logic [7:0]  VRAM_BANK_LO = 8'h10,
  parameter logic [7:0]  VRAM_BANK_HI = 8'h1F
) (
  input  logic [23:0] cpu_addr,
  output region_t     region
);

  logic [7:0] bank;
  logic [7:0] page;
  logic [7:0] off;

  assign bank = cpu_addr[23:16];
  assign page = cpu_addr[15:8];
  assign off  = cpu_addr[7:0];

  // Anything in bank 00 outside the I/O page, or outside the VRAM banks, is RAM
  always_comb begin
    region = REG_RAM;
    if (bank >= VRAM_BANK_LO && bank <= VRAM_BANK_HI) begin
      region = REG_VRAM;
    end else if (bank == 8'h00 && page == IO_PAGE[15:8]) begin
      if (off <= OFF_VIDEO_HI)      region = REG_VIDEO;
      else if (off <= OFF_IRQ_HI)   region = REG_IRQ;
      else if (off <= OFF_SPI_HI)   region = REG_SPI;
      else if (off <= OFF_MMU_HI)   region = REG_MMU;
      else                          region = REG_EXT;
    end
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// CPU bus cycle sequencer: decodes each cycle to a region, drives the active-low
// selects and stretches the cycle with per-region wait states and VRAM arbitration.
module bus_cycle_ctrl
  import zeus_bus_pkg::*;
#(
  parameter logic [15:0] IO_PAGE      = 16'hFE00,
  parameter logic [7:0]  VRAM_BANK_LO = 8'h10,
  parameter logic [7:0]  VRAM_BANK_HI = 8'h1F,
  parameter int          WS_IO        = 1,
  parameter int          WS_RAM       = 0,
  parameter int          WS_VRAM      = 2,
  parameter int          WS_EXT       = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cycle_start,
  input  logic        cycle_end,
  input  logic [23:0] cpu_addr,
  input  logic        read_write,
  input  logic        vram_busy,
  output logic        io_video_n,
  output logic        io_irq_n,
  output logic        io_spi_n,
  output logic        io_mmu_n,
  output logic        ram_cs_n,
  output logic        vram_cs_n,
  output logic        rw_latched,
  output logic        cpu_rdy,
  output logic        proto_err
);

  localparam int WS_MAX = max4(WS_IO, WS_RAM, WS_VRAM, WS_EXT);
  localparam int CW     = (WS_MAX > 0) ? $clog2(WS_MAX + 1) : 1;

  if (WS_IO > 15 || WS_RAM > 15 || WS_VRAM > 15 || WS_EXT > 15) begin : g_ws_range
    $error("bus_cycle_ctrl: wait-state parameters above 15 are not supported");
  end

  function automatic logic [CW-1:0] ws_for(input region_t r);
    case (r)
      REG_RAM:  return CW'(WS_RAM);
      REG_VRAM: return CW'(WS_VRAM);
      REG_EXT:  return CW'(WS_EXT);
      default:  return CW'(WS_IO);
    endcase
  endfunction

  region_t        region_d;
  region_t        region_q;
  state_t         state;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_dec;
  logic [CW-1:0]  ws_new;
  logic [5:0]     sel_n;
  logic           start_wait;
  logic           vram_block;
  logic           do_load;

  bus_region_decode #(
    .IO_PAGE      (IO_PAGE),
    .VRAM_BANK_LO (VRAM_BANK_LO),
    .VRAM_BANK_HI (VRAM_BANK_HI)
  ) u_decode (
    .cpu_addr (cpu_addr),
    .region   (region_d)
  );

  assign ws_new     = ws_for(region_d);
  assign start_wait = (ws_new != '0) || (region_d == REG_VRAM && vram_busy);
  assign count_dec  = (count == '0) ? '0 : count - CW'(1);
  assign vram_block = (region_q == REG_VRAM) && vram_busy;
  // Back-to-back cycles load straight from ACTIVE; a start during WAIT is a violation
  assign do_load    = cycle_start && (state != ST_WAIT);

  // The wait counter holds the wait clocks still owed, so cpu_rdy stays low for exactly WS clocks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      region_q   <= REG_RAM;
      count      <= '0;
      sel_n      <= SEL_NONE;
      rw_latched <= 1'b1;
      cpu_rdy    <= 1'b1;
      proto_err  <= 1'b0;
    end else begin
      proto_err <= (state == ST_WAIT && (cycle_start || cycle_end)) ||
                   (state == ST_IDLE && cycle_end && !cycle_start);
      if (do_load) begin
        region_q   <= region_d;
        sel_n      <= sel_for(region_d);
        rw_latched <= read_write;
        count      <= ws_new;
        state      <= start_wait ? ST_WAIT : ST_ACTIVE;
        cpu_rdy    <= !start_wait;
      end else if (state == ST_WAIT) begin
        count <= count_dec;
        if (count_dec == '0 && !vram_block) begin
          state   <= ST_ACTIVE;
          cpu_rdy <= 1'b1;
        end
      end else if (state == ST_ACTIVE && cycle_end) begin
        sel_n      <= SEL_NONE;
        rw_latched <= 1'b1;
        state      <= ST_IDLE;
      end
    end
  end

  assign io_video_n = sel_n[SEL_VIDEO];
  assign io_irq_n   = sel_n[SEL_IRQ];
  assign io_spi_n   = sel_n[SEL_SPI];
  assign io_mmu_n   = sel_n[SEL_MMU];
  assign ram_cs_n   = sel_n[SEL_RAM];
  assign vram_cs_n  = sel_n[SEL_VRAM];

endmodule
